// File: rtl/adder_mon_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
// The FSM encoding and default datapath widths live here.
package adder_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int RES_W     = DEF_WIDTH + 1;
    localparam int DEF_ACC_W = 48;
    localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

endpackage

// File: rtl/error_distance32.sv
// Combinational datapath: recomputes the exact sum of the operands and
// returns the unsigned distance to the approximate adder's result.
module error_distance32
    import adder_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] add1,
    input  logic [WIDTH-1:0] add2,
    input  logic [WIDTH:0]   approx,
    output logic [WIDTH:0]   ed
);

    logic [WIDTH:0] exact;

    // Compare first so the subtraction never underflows.
    always_comb begin
        exact = {1'b0, add1} + {1'b0, add2};
        if (exact >= approx) begin
            ed = exact - approx;
        end else begin
            ed = approx - exact;
        end
    end

endmodule

// File: rtl/adder_error_monitor32.sv
// Windowed error-statistics monitor for a 32-bit approximate adder:
// accepts N samples, pipelines the error distance and accumulates stats.
module adder_error_monitor32
    import adder_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 32,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] num_samples_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   approx_result_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sample_count_o,
    output logic [CNT_W-1:0] error_count_o,
    output logic [ACC_W-1:0] ed_sum_o,
    output logic [WIDTH:0]   ed_max_o
);

    localparam logic [ACC_W-1:0] SUM_MAX = '1;

    state_t           state, next_state;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] accepted;
    logic             v1, v2;
    logic [WIDTH-1:0] add1_q, add2_q;
    logic [WIDTH:0]   approx_q;
    logic [WIDTH:0]   ed_c, ed_q;
    logic [ACC_W:0]   sum_ext;
    logic             transfer;
    logic             start_win;

    assign ready_o   = (state == RUN) && (accepted < n_reg);
    assign transfer  = valid_i && ready_o;
    assign start_win = start_i && !clear_i && ((state == IDLE) || (state == DONE));
    assign busy_o    = (state == RUN) || (state == DRAIN);
    assign done_o    = (state == DONE);
    assign sum_ext   = {1'b0, ed_sum_o} + {{(ACC_W - WIDTH){1'b0}}, ed_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear_i) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start_i) next_state = RUN;
                RUN:     if (accepted == n_reg) next_state = DRAIN;
                DRAIN:   if (!v1 && !v2) next_state = DONE;
                DONE:    if (start_i) next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    error_distance32 #(.WIDTH(WIDTH)) u_ed (
        .add1   (add1_q),
        .add2   (add2_q),
        .approx (approx_q),
        .ed     (ed_c)
    );

    // clear_i flushes both stages so in-flight samples never reach the stats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            add1_q   <= '0;
            add2_q   <= '0;
            approx_q <= '0;
            ed_q     <= '0;
        end else if (clear_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= transfer;
            v2 <= v1;
            if (transfer) begin
                add1_q   <= add1_i;
                add2_q   <= add2_i;
                approx_q <= approx_result_i;
            end
            if (v1) begin
                ed_q <= ed_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_reg          <= '0;
            accepted       <= '0;
            sample_count_o <= '0;
            error_count_o  <= '0;
            ed_sum_o       <= '0;
            ed_max_o       <= '0;
        end else if (clear_i || start_win) begin
            n_reg          <= start_win ? num_samples_i : '0;
            accepted       <= '0;
            sample_count_o <= '0;
            error_count_o  <= '0;
            ed_sum_o       <= '0;
            ed_max_o       <= '0;
        end else begin
            if (transfer) begin
                accepted <= accepted + 1'b1;
            end
            if (v2) begin
                sample_count_o <= sample_count_o + 1'b1;
                if (ed_q != '0) begin
                    error_count_o <= error_count_o + 1'b1;
                end
                ed_sum_o <= sum_ext[ACC_W] ? SUM_MAX : sum_ext[ACC_W-1:0];
                if (ed_q > ed_max_o) begin
                    ed_max_o <= ed_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_error_monitor32.sv
// Scoreboard bench for adder_error_monitor32: expected ED values are queued
// at each transfer and checked against the stats deltas as samples retire.
module tb_adder_error_monitor32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] num_samples = '0;
    logic        valid = 1'b0;
    logic [31:0] add1 = '0;
    logic [31:0] add2 = '0;
    logic [32:0] approx = '0;

    logic        ready, busy, done;
    logic [31:0] sample_count, error_count;
    logic [47:0] ed_sum;
    logic [32:0] ed_max;

    logic        ready_s, busy_s, done_s;
    logic [31:0] sample_count_s, error_count_s;
    logic [33:0] ed_sum_s;
    logic [32:0] ed_max_s;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    adder_error_monitor32 dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
        .num_samples_i(num_samples), .valid_i(valid), .ready_o(ready),
        .add1_i(add1), .add2_i(add2), .approx_result_i(approx),
        .busy_o(busy), .done_o(done), .sample_count_o(sample_count),
        .error_count_o(error_count), .ed_sum_o(ed_sum), .ed_max_o(ed_max)
    );

    adder_error_monitor32 #(.ACC_W(34)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
        .num_samples_i(num_samples), .valid_i(valid), .ready_o(ready_s),
        .add1_i(add1), .add2_i(add2), .approx_result_i(approx),
        .busy_o(busy_s), .done_o(done_s), .sample_count_o(sample_count_s),
        .error_count_o(error_count_s), .ed_sum_o(ed_sum_s), .ed_max_o(ed_max_s)
    );

    function automatic logic [32:0] model_ed(input logic [31:0] a, input logic [31:0] b,
                                             input logic [32:0] ap);
        logic [32:0] ex;
        ex = {1'b0, a} + {1'b0, b};
        return (ex >= ap) ? (ex - ap) : (ap - ex);
    endfunction

    // Push on transfer, pop when sample_count advances by one.
    initial begin
        logic [31:0] prev_cnt, prev_err;
        logic [47:0] prev_sum;
        logic [32:0] prev_max, exp_ed, exp_max;
        prev_cnt = '0; prev_err = '0; prev_sum = '0; prev_max = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (valid && ready && !clear) sb.push_back(model_ed(add1, add2, approx));
                if (sample_count == prev_cnt + 32'd1) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL sb_underflow: sample retired count=%0d with queue empty", sample_count);
                    end else begin
                        exp_ed  = sb.pop_front();
                        exp_max = (exp_ed > prev_max) ? exp_ed : prev_max;
                        if (ed_sum - prev_sum !== {15'd0, exp_ed}) begin
                            n_fail++;
                            $display("[TB] FAIL sb_ed_delta: got %h expected %h", ed_sum - prev_sum, exp_ed);
                        end
                        n_cmp++;
                        if (error_count - prev_err !== {31'd0, exp_ed != 33'd0}) begin
                            n_fail++;
                            $display("[TB] FAIL sb_err_delta: got %0d expected %0d", error_count - prev_err, exp_ed != 33'd0);
                        end
                        n_cmp++;
                        if (ed_max !== exp_max) begin
                            n_fail++;
                            $display("[TB] FAIL sb_ed_max: got %h expected %h", ed_max, exp_max);
                        end
                    end
                end
            end
            prev_cnt = sample_count; prev_err = error_count;
            prev_sum = ed_sum;       prev_max = ed_max;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input logic [31:0] n);
        num_samples = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [32:0] ap);
        bit ok;
        ok = 1'b0;
        add1 = a; add2 = b; approx = ap; valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ready) ok = 1'b1;
            step();
        end
        valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL send_timeout: ready got 0 for 20 cycles required 1");
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (done) ok = 1'b1;
            else step();
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL done_timeout: done got 0 after 50 cycles required 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({ready, busy, done} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b required 000", {ready, busy, done});
        end
        n_cmp++;
        if (sample_count !== 0 || error_count !== 0 || ed_sum !== 0 || ed_max !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_stats: got %0d/%0d/%h/%h required zeros", sample_count, error_count, ed_sum, ed_max);
        end
    endtask

    task automatic test_exact();
        start_window(32'd4);
        send(32'd1, 32'd2, 33'd3);
        send(32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000);
        send(32'd5, 32'd5, 33'd10);
        send(32'd0, 32'd0, 33'd0);
        wait_done();
        n_cmp++;
        if (sample_count !== 32'd4 || error_count !== 32'd0 || ed_sum !== 48'd0 || ed_max !== 33'd0 || done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL exact_stats: got cnt=%0d err=%0d sum=%h max=%h done=%b required 4/0/0/0/1",
                     sample_count, error_count, ed_sum, ed_max, done);
        end
    endtask

    task automatic test_errors();
        start_window(32'd3);
        send(32'd10, 32'd20, 33'd37);
        send(32'd100, 32'd200, 33'd298);
        send(32'd7, 32'd8, 33'd15);
        wait_done();
        n_cmp++;
        if (sample_count !== 32'd3 || error_count !== 32'd2 || ed_sum !== 48'd9 || ed_max !== 33'd7) begin
            n_fail++;
            $display("[TB] FAIL error_stats: got cnt=%0d err=%0d sum=%0d max=%0d required 3/2/9/7",
                     sample_count, error_count, ed_sum, ed_max);
        end
    endtask

    task automatic test_boundary();
        start_window(32'd3);
        repeat (3) send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'd0);
        wait_done();
        n_cmp++;
        if (ed_max !== 33'h1_FFFF_FFFE || ed_sum !== 48'h5_FFFF_FFFA || error_count !== 32'd3) begin
            n_fail++;
            $display("[TB] FAIL boundary_ed: got max=%h sum=%h err=%0d required 1fffffffe/5fffffffa/3",
                     ed_max, ed_sum, error_count);
        end
        n_cmp++;
        if (ed_sum_s !== 34'h3_FFFF_FFFF || ed_max_s !== 33'h1_FFFF_FFFE || sample_count_s !== 32'd3) begin
            n_fail++;
            $display("[TB] FAIL saturation: got sum=%h max=%h cnt=%0d required 3ffffffff/1fffffffe/3",
                     ed_sum_s, ed_max_s, sample_count_s);
        end
    endtask

    task automatic test_handshake();
        int ready_cycles;
        ready_cycles = 0;
        start_window(32'd2);
        add1 = 32'd3; add2 = 32'd4; approx = 33'd7; valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (ready) ready_cycles++;
            step();
        end
        valid = 1'b0;
        wait_done();
        n_cmp++;
        if (ready_cycles != 2 || sample_count !== 32'd2) begin
            n_fail++;
            $display("[TB] FAIL handshake: got ready_cycles=%0d cnt=%0d required 2/2", ready_cycles, sample_count);
        end
        start_window(32'd0);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL n0_first: got done=%b busy=%b required 0/1", done, busy);
        end
        step();
        step();
        n_cmp++;
        if (done !== 1'b1 || sample_count !== 0 || ed_sum !== 0 || ed_max !== 0) begin
            n_fail++;
            $display("[TB] FAIL n0_done: got done=%b cnt=%0d sum=%h max=%h required 1/0/0/0", done, sample_count, ed_sum, ed_max);
        end
    endtask

    task automatic test_clear();
        start_window(32'd5);
        send(32'd1, 32'd1, 33'd9);
        send(32'd2, 32'd2, 33'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        sb.delete();
        n_cmp++;
        if ({ready, busy, done} !== 3'b000 || sample_count !== 0) begin
            n_fail++;
            $display("[TB] FAIL clear_idle: got flags=%b cnt=%0d required 000/0", {ready, busy, done}, sample_count);
        end
        repeat (4) step();
        n_cmp++;
        if (sample_count !== 0 || error_count !== 0 || ed_sum !== 0 || ed_max !== 0) begin
            n_fail++;
            $display("[TB] FAIL clear_drop: got %0d/%0d/%h/%h required zeros", sample_count, error_count, ed_sum, ed_max);
        end
        num_samples = 32'd3;
        start = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; clear = 1'b0;
        step();
        n_cmp++;
        if ({ready, busy, done} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL start_clear: got flags=%b required 000", {ready, busy, done});
        end
    endtask

    task automatic test_async_reset();
        start_window(32'd4);
        send(32'd1, 32'd1, 33'd6);
        send(32'd1, 32'd1, 33'd6);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        n_cmp++;
        if ({ready, busy, done} !== 3'b000 || sample_count !== 0 || error_count !== 0 || ed_sum !== 0 || ed_max !== 0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got flags=%b cnt=%0d err=%0d sum=%h max=%h required zeros",
                     {ready, busy, done}, sample_count, error_count, ed_sum, ed_max);
        end
        #1;
        rst_n = 1'b1;
        step();
        start_window(32'd2);
        send(32'd40, 32'd2, 33'd40);
        send(32'd8, 32'd8, 33'd16);
        wait_done();
        n_cmp++;
        if (sample_count !== 32'd2 || error_count !== 32'd1 || ed_sum !== 48'd2 || ed_max !== 33'd2) begin
            n_fail++;
            $display("[TB] FAIL post_reset: got cnt=%0d err=%0d sum=%0d max=%0d required 2/1/2/2",
                     sample_count, error_count, ed_sum, ed_max);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_errors();
        test_boundary();
        test_handshake();
        test_clear();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL sb_leftover: got %0d entries required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
